demux1to4_reg: RTL
==================

DEMUX1TO4_REG -- requirements
Module: demux1to4_reg

Interface
REQ-001 Parameter WIDTH, default 32, data path width in bits.
REQ-002 The block SHALL have one clock; reset is asynchronous and active-low.
REQ-003 clk  input  1  rising-edge clock.
REQ-004 reset_n  input  1  asynchronous active-low reset.
REQ-005 in_valid  input  1  producer offers one word this cycle.
REQ-006 in_ready  output  1  block accepts the offered word this cycle (combinational).
REQ-007 selector  input  2  destination channel 0..3, sampled with in_valid.
REQ-008 bcast  input  1  when 1, the word goes to all four channels and selector is ignored.
REQ-009 Data_in  input  WIDTH  word to distribute.
REQ-010 out_valid  output  4  bit i = channel i holds an unconsumed word.
REQ-011 out_ack  input  4  bit i = consumer i takes channel i's word this cycle.
REQ-012 Data_out_0..Data_out_3  output  WIDTH each  per-channel holding registers.
REQ-013 xfer_count  output  16  count of accepted input words.

Function
REQ-014 Channel i SHALL be "free" this cycle when out_valid[i]==0 or out_ack[i]==1.
REQ-015 Unicast: in_ready SHALL equal free[selector]; broadcast: in_ready SHALL equal AND of free[0..3].
REQ-016 A transfer SHALL occur on a rising edge where in_valid && in_ready.
REQ-017 On a unicast transfer, Data_out_<selector> SHALL load Data_in and out_valid[selector] SHALL be 1 the next cycle; other channels are unchanged except for REQ-019.
REQ-018 On a broadcast transfer, all four Data_out registers SHALL load Data_in and all out_valid bits SHALL be 1 the next cycle.
REQ-019 On an edge with out_valid[i] && out_ack[i] and no load into channel i, out_valid[i] SHALL clear; Data_out_i SHALL hold its value.
REQ-020 Same-cycle ack and load on channel i SHALL leave out_valid[i]=1 with the new data (pass-through, zero bubble).
REQ-021 out_ack[i] while out_valid[i]==0 SHALL have no effect.
REQ-022 Each channel SHALL have a two-state FSM, EMPTY->FULL on load, FULL->EMPTY on ack without load, FULL->FULL on ack with load or on no ack; out_valid[i] = (state==FULL).
REQ-023 Latency: data SHALL be visible on Data_out_i one cycle after the accepting edge.
REQ-024 Blocked input (in_ready==0) SHALL not change any channel; the producer holds in_valid, selector, bcast and Data_in until accepted.
REQ-025 xfer_count SHALL increment by 1 per transfer (broadcast counts once) and wrap from 16'hFFFF to 0.
REQ-026 in_ready SHALL not depend on in_valid.

Reset
REQ-027 While reset_n==0, all channel FSMs SHALL be EMPTY, out_valid=4'b0000, Data_out_0..3 = 0 and xfer_count = 0, asynchronously.
REQ-028 Reset asserted mid-operation SHALL discard held words without an ack; in_ready SHALL be 1 during reset for any selector.
REQ-029 The first transfer SHALL be possible on the first rising edge after reset_n deasserts.

Verification
REQ-030 After reset, unicast sel=2, Data_in=32'hDEADBEEF -> next cycle out_valid=4'b0100, Data_out_2=32'hDEADBEEF, xfer_count=1.
REQ-031 Channel 1 full, no ack; offer sel=1 -> in_ready=0 and channel 1 is unchanged; then offer sel=3 -> accepted, out_valid=4'b1010.
REQ-032 Channel 0 full with 32'h11; same cycle out_ack=4'b0001 and offer sel=0, 32'h22 -> in_ready=1, next cycle out_valid[0]=1, Data_out_0=32'h22.
REQ-033 Broadcast 32'hA5A5A5A5 with channel 3 full and unacked -> in_ready=0; assert out_ack[3] -> accepted, all Data_out=32'hA5A5A5A5, out_valid=4'b1111, xfer_count incremented by 1.
REQ-034 Drive 65536 unicast transfers with continuous acks -> xfer_count returns to 0.
REQ-035 Pulse reset_n low asynchronously between edges with out_valid=4'b1111 -> outputs clear immediately; the first post-reset transfer succeeds.

Source files
------------

// File: rtl/demux1to4_reg.sv
// Registered 1-to-4 demultiplexer with per-channel holding registers, valid/ack
// handshake on each output, unicast or broadcast input, and a transfer counter.
module demux1to4_reg #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       selector,
    input  logic             bcast,
    input  logic [WIDTH-1:0] Data_in,
    output logic [3:0]       out_valid,
    input  logic [3:0]       out_ack,
    output logic [WIDTH-1:0] Data_out_0,
    output logic [WIDTH-1:0] Data_out_1,
    output logic [WIDTH-1:0] Data_out_2,
    output logic [WIDTH-1:0] Data_out_3,
    output logic [15:0]      xfer_count
);

    typedef enum logic {
        CH_EMPTY = 1'b0,
        CH_FULL  = 1'b1
    } ch_state_e;

    ch_state_e        state_q [4];
    ch_state_e        state_d [4];
    logic [WIDTH-1:0] data_q  [4];
    logic [WIDTH-1:0] data_d  [4];
    logic [15:0]      count_q;
    logic [15:0]      count_d;
    logic [3:0]       free_s;
    logic [3:0]       load_s;
    logic             xfer_s;

    // Acceptance: a channel can take a word if empty or being drained this cycle.
    always_comb begin
        free_s   = 4'b0000;
        in_ready = 1'b0;
        xfer_s   = 1'b0;
        load_s   = 4'b0000;
        for (int i = 0; i < 4; i++) begin
            free_s[i] = (state_q[i] == CH_EMPTY) || out_ack[i];
        end
        if (bcast) begin
            in_ready = &free_s;
        end else begin
            in_ready = free_s[selector];
        end
        xfer_s = in_valid && in_ready;
        for (int i = 0; i < 4; i++) begin
            if (xfer_s && (bcast || (selector == 2'(i)))) begin
                load_s[i] = 1'b1;
            end else begin
                load_s[i] = 1'b0;
            end
        end
    end

    // Per-channel next state and holding-register data; a load wins over an ack.
    always_comb begin
        for (int i = 0; i < 4; i++) begin
            state_d[i] = state_q[i];
            data_d[i]  = data_q[i];
            case (state_q[i])
                CH_EMPTY: begin
                    if (load_s[i]) begin
                        state_d[i] = CH_FULL;
                    end else begin
                        state_d[i] = CH_EMPTY;
                    end
                end
                CH_FULL: begin
                    if (load_s[i]) begin
                        state_d[i] = CH_FULL;
                    end else if (out_ack[i]) begin
                        state_d[i] = CH_EMPTY;
                    end else begin
                        state_d[i] = CH_FULL;
                    end
                end
                default: begin
                    state_d[i] = CH_EMPTY;
                end
            endcase
            if (load_s[i]) begin
                data_d[i] = Data_in;
            end else begin
                data_d[i] = data_q[i];
            end
        end
    end

    // Transfer counter, wraps naturally at 16 bits; broadcast counts once.
    always_comb begin
        if (xfer_s) begin
            count_d = count_q + 16'd1;
        end else begin
            count_d = count_q;
        end
    end

    // State, data and counter registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < 4; i++) begin
                state_q[i] <= CH_EMPTY;
                data_q[i]  <= {WIDTH{1'b0}};
            end
            count_q <= 16'd0;
        end else begin
            for (int i = 0; i < 4; i++) begin
                state_q[i] <= state_d[i];
                data_q[i]  <= data_d[i];
            end
            count_q <= count_d;
        end
    end

    // Output mapping straight from the registers.
    always_comb begin
        for (int i = 0; i < 4; i++) begin
            out_valid[i] = (state_q[i] == CH_FULL);
        end
        Data_out_0 = data_q[0];
        Data_out_1 = data_q[1];
        Data_out_2 = data_q[2];
        Data_out_3 = data_q[3];
        xfer_count = count_q;
    end

endmodule
